// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: splits 256-bit cache line requests into four
// 64-bit memory beats and reassembles fill beats into a full line.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic         line_resp,
  output logic [255:0] line_rdata,
  output logic         burst_read,
  output logic         burst_write,
  output logic [31:0]  burst_address,
  output logic [63:0]  burst_wdata,
  input  logic         burst_resp,
  input  logic [63:0]  burst_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [1:0]   cnt;
  logic [31:0]  addr_q;
  logic [255:0] wbuf;
  logic [255:0] rbuf;
  logic [255:0] fill_line;
  logic         accept_rd;
  logic         accept_wr;
  logic         last_beat;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^line_address[4:0];
  assign last_beat = burst_resp && (cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    unique case (state)
      IDLE: begin
        if (line_read) begin
          accept_rd = 1'b1;
          state_n   = READ;
        end else if (line_write) begin
          accept_wr = 1'b1;
          state_n   = WRITE;
        end
      end
      READ:    if (last_beat) state_n = DONE;
      WRITE:   if (last_beat) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Current line with the incoming beat dropped into its slot
  always_comb begin
    fill_line = rbuf;
    fill_line[{cnt, 6'b0} +: 64] = burst_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      addr_q     <= 32'd0;
      wbuf       <= 256'd0;
      rbuf       <= 256'd0;
      line_rdata <= 256'd0;
    end else begin
      if (accept_rd || accept_wr) begin
        addr_q <= {line_address[31:5], 5'b0};
        cnt    <= 2'd0;
      end
      if (accept_wr)
        wbuf <= line_wdata;
      if ((state == READ || state == WRITE) && burst_resp)
        cnt <= cnt + 2'd1;
      if (state == READ && burst_resp)
        rbuf <= fill_line;
      if (state == READ && last_beat)
        line_rdata <= fill_line;
    end
  end

  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign line_resp     = (state == DONE);
  assign burst_address = addr_q;
  assign burst_wdata   = wbuf[{cnt, 6'b0} +: 64];

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts the cache's 256-bit line-granular physical-memory requests into four 64-bit beats on the burst memory bus, and reassembles read beats into a full line. It sits directly downstream of the cache's pmem port: the cache's pmem_read/pmem_write/pmem_address/pmem_wdata drive the line side, and line_resp/line_rdata return as pmem_resp/pmem_rdata. Only one line transfer is in flight at a time.

## Interface
- No parameters; line width 256, beat width 64, 4 beats per line are fixed.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- line_read  in  1  line fill request, held until line_resp
- line_write  in  1  line writeback request, held until line_resp
- line_address  in  32  line address; bits [4:0] ignored
- line_wdata  in  256  writeback line, sampled at request acceptance
- line_resp  out  1  one-cycle completion pulse
- line_rdata  out  256  assembled fill line, valid with line_resp, held until next fill completes
- burst_read  out  1  burst read request, held through all 4 beats
- burst_write  out  1  burst write request, held through all 4 beats
- burst_address  out  32  line-aligned address, {line_address[31:5], 5'b0}
- burst_wdata  out  64  current write beat
- burst_resp  in  1  beat handshake: read data valid / write beat accepted
- burst_rdata  in  64  read beat data, valid when burst_resp=1

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter.
- IDLE: if line_read, latch aligned address, counter=0, go READ. Else if line_write, latch address and line_wdata, counter=0, go WRITE. Both asserted: read wins (illegal from the cache, but defined). burst_resp in IDLE ignored.
- READ: burst_read=1. On each burst_resp=1, store burst_rdata into line slot [64*counter+63 : 64*counter], counter++. Beat 0 is bits [63:0], ascending. On the beat with counter==3, go DONE.
- WRITE: burst_write=1, burst_wdata = latched line slot selected by counter. On burst_resp=1, counter++; on the beat with counter==3, go DONE.
- Gaps (burst_resp=0 cycles) allowed between beats; counter and data hold.
- DONE: line_resp=1 for exactly one cycle, burst_read/burst_write=0, then IDLE.
- line_rdata updates only from completed fills; a writeback leaves it unchanged.
- burst_address holds latched value from acceptance until the next acceptance.
- Counter wraps 3->0 on the final beat.

## Timing
- burst_read/burst_write/line_resp decoded from state (registered-state Moore outputs); no combinational path from burst_resp to any output.
- Request seen in IDLE at cycle 0 -> burst_read/write high from cycle 1.
- Beats on cycles 1-4 (back-to-back) -> line_resp at cycle 5; minimum latency 5 cycles. Each stall cycle adds one.
- Cycle after line_resp the adaptor is IDLE and may accept a new request; requester deasserts line_read/line_write in that cycle.
- Reset (any time, including mid-burst): state=IDLE, counter=0, line_resp=0, line_rdata=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, internal line buffers cleared. A partial burst is abandoned; no line_resp is issued for it.

## Test plan
- Fill: line_read, line_address=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> burst_address=0x0000_1220, line_resp at cycle 5, line_rdata={0x44..,0x33..,0x22..,0x11..}.
- Writeback: line_write, line_wdata={0xD..,0xC..,0xB..,0xA..} (64-bit each), memory acks every cycle -> burst_wdata sequence 0xA..,0xB..,0xC..,0xD.., line_resp at cycle 5, line_rdata unchanged.
- Stalled fill: burst_resp pattern 1,0,0,1,1,0,1 -> line_resp exactly one cycle after the 4th beat, data in correct slots, no extra beats captured.
- Simultaneous line_read and line_write -> read burst performed, burst_write stays 0.
- Reset asserted after 2 read beats -> all outputs 0 immediately, no line_resp; a fresh fill then completes normally with correct data.
- Back-to-back writeback then fill (cache eviction) -> second request accepted the cycle after first line_resp, two distinct line_resp pulses, no cycle with burst_read and burst_write both high.
